// File: rtl/mc_fifo_rr_drain.sv
// Multi-channel synchronous FIFO bank that drains into one registered valid/ready
// output port, using round-robin or fixed-priority arbitration between channels.

module mc_fifo_rr_drain_ch #(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_THRESH = 14,
    parameter int CW           = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  afull,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic                  overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THRESH = CW'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  wr_ok;

    assign full  = (cnt == DEPTH);
    assign afull = (cnt >= THRESH);
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // A full channel still accepts a write when its head leaves in the same cycle.
    assign wr_ok = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (wr_en && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_ptr] <= wr_data;
    end
endmodule

module mc_fifo_rr_drain #(
    parameter int NUM_CH       = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_THRESH = FIFO_DEPTH - 2,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1,
    localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        afull,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH*CW-1:0]     count,
    output logic [NUM_CH-1:0]        overflow,
    input  logic                     prio_mode,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic [CHW-1:0]           m_ch
);
    typedef struct packed {
        logic [CHW-1:0]        ch;
        logic [DATA_WIDTH-1:0] data;
    } out_word_t;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] heads;
    logic [NUM_CH-1:0]                 pop;
    logic [CHW-1:0]                    rr_ptr, gnt_id, rr_nxt;
    logic                              gnt_vld, load;
    out_word_t                         out_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mc_fifo_rr_drain_ch #(
            .DATA_WIDTH  (DATA_WIDTH),
            .FIFO_DEPTH  (FIFO_DEPTH),
            .AFULL_THRESH(AFULL_THRESH),
            .CW          (CW)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[i]),
            .wr_data (wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop     (pop[i]),
            .head    (heads[i]),
            .full    (full[i]),
            .afull   (afull[i]),
            .empty   (empty[i]),
            .count   (count[i*CW +: CW]),
            .overflow(overflow[i])
        );
    end

    assign load = !m_valid || m_ready;

    // Scan from rr_ptr (round-robin) or from 0 (fixed priority); first non-empty wins.
    always_comb begin
        int             idx;
        logic [CHW-1:0] idx_c;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        idx_c   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = prio_mode ? k : int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_c = CHW'(idx);
            if (!gnt_vld && !empty[idx_c]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx_c;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (load && gnt_vld) pop[gnt_id] = 1'b1;
    end

    assign rr_nxt = (gnt_id == CHW'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            m_valid <= 1'b0;
            out_q   <= '0;
        end else if (load) begin
            m_valid <= gnt_vld;
            if (gnt_vld) begin
                out_q.ch   <= gnt_id;
                out_q.data <= heads[gnt_id];
                if (!prio_mode) rr_ptr <= rr_nxt;
            end
        end
    end

    assign m_data = out_q.data;
    assign m_ch   = out_q.ch;
endmodule

// File: tb/tb_mc_fifo_rr_drain.sv
// Directed bench for mc_fifo_rr_drain: a cycle vector table plus hand-written
// sequences for ordering, overflow, wrap, arbitration and reset corner cases.

module tb_mc_fifo_rr_drain;
    localparam int NCH = 16;
    localparam int DW  = 16;
    localparam int CW  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    wr_en = '0;
    logic [NCH*DW-1:0] wr_data = '0;
    logic [NCH-1:0]    full, afull, empty, overflow;
    logic [NCH*CW-1:0] count;
    logic              prio_mode = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DW-1:0]     m_data;
    logic [3:0]        m_ch;

    int total = 0;
    int bad   = 0;
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    mc_fifo_rr_drain dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .afull(afull), .empty(empty), .count(count),
        .overflow(overflow), .prio_mode(prio_mode), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch)
    );

    typedef struct {
        logic        rst;
        int          wch;
        logic [15:0] wval;
        logic        rdy;
        logic        prio;
        logic        ev;
        logic [3:0]  ech;
        logic [15:0] edata;
        logic [15:0] eempty;
        int          cch;
        logic [4:0]  ecnt;
    } vec_t;

    function automatic vec_t mk(logic r, int wc, logic [15:0] wv, logic rd, logic pr,
                                logic ev, logic [3:0] ec, logic [15:0] ed,
                                logic [15:0] ee, int cc, logic [4:0] en);
        vec_t v;
        v.rst = r; v.wch = wc; v.wval = wv; v.rdy = rd; v.prio = pr;
        v.ev = ev; v.ech = ec; v.edata = ed; v.eempty = ee; v.cch = cc; v.ecnt = en;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] cnt_of(int c);
        return count[c*CW +: CW];
    endfunction

    // Handshake happens at the coming edge if valid & ready are high now.
    task automatic tick();
        if (m_valid && m_ready) got_q.push_back({m_ch, m_data});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = '0; m_ready = 1'b0; prio_mode = 1'b0;
        tick(); tick();
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({nm, "_word"}, {12'h0, got_q[i]}, {12'h0, exp_q[i]});
    endtask

    vec_t tbl[14];

    initial begin
        // reset and idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", m_valid, 0);
            chk("idle_empty", empty, 16'hFFFF);
            chk("idle_full", full, 0);
            chk("idle_count", count, 0);
        end

        // cycle vector table: rst wch wval rdy prio | ev ech edata eempty cch ecnt
        tbl[0]  = mk(1, -1, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 3, 0);
        tbl[1]  = mk(1,  3, 16'hAAAA, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 3, 0);
        tbl[2]  = mk(0,  3, 16'h0101, 0, 0, 0, 0, 16'h0000, 16'hFFF7, 3, 1);
        tbl[3]  = mk(0,  5, 16'h0505, 0, 0, 1, 3, 16'h0101, 16'hFFDF, 3, 0);
        tbl[4]  = mk(0, -1, 16'h0000, 0, 0, 1, 3, 16'h0101, 16'hFFDF, 5, 1);
        tbl[5]  = mk(0, -1, 16'h0000, 1, 0, 1, 5, 16'h0505, 16'hFFFF, 5, 0);
        tbl[6]  = mk(0, -1, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 5, 0);
        tbl[7]  = mk(0,  3, 16'h0303, 1, 0, 0, 0, 16'h0000, 16'hFFF7, 3, 1);
        tbl[8]  = mk(0,  3, 16'h0304, 1, 0, 1, 3, 16'h0303, 16'hFFF7, 3, 1);
        tbl[9]  = mk(0, -1, 16'h0000, 1, 0, 1, 3, 16'h0304, 16'hFFFF, 3, 0);
        tbl[10] = mk(0,  0, 16'h0A00, 0, 1, 1, 3, 16'h0304, 16'hFFFE, 0, 1);
        tbl[11] = mk(0,  9, 16'h0909, 1, 1, 1, 0, 16'h0A00, 16'hFDFF, 9, 1);
        tbl[12] = mk(0, -1, 16'h0000, 1, 0, 1, 9, 16'h0909, 16'hFFFF, 9, 0);
        tbl[13] = mk(0, -1, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0);
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; m_ready = tbl[i].rdy; prio_mode = tbl[i].prio;
            wr_en = '0; wr_data = '0;
            if (tbl[i].wch >= 0) begin
                wr_en[tbl[i].wch] = 1'b1;
                wr_data[tbl[i].wch*DW +: DW] = tbl[i].wval;
            end
            tick();
            chk("vec_valid", m_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("vec_ch", m_ch, tbl[i].ech);
                chk("vec_data", m_data, tbl[i].edata);
            end
            chk("vec_empty", empty, tbl[i].eempty);
            chk("vec_count", cnt_of(tbl[i].cch), tbl[i].ecnt);
        end
        wr_en = '0; rst = 1'b0;

        // single channel order and 2-edge latency
        begin
            logic saw_full;
            do_reset();
            m_ready = 1'b1; saw_full = 1'b0; exp_q.delete();
            for (int c = 0; c < 20; c++) begin
                wr_en = '0;
                if (c < 16) begin
                    wr_en[3] = 1'b1;
                    wr_data[3*DW +: DW] = 16'(c + 1);
                    exp_q.push_back({4'd3, 16'(c + 1)});
                end
                tick();
                if (full != '0) saw_full = 1'b1;
                if (c == 0) chk("lat_first_edge", m_valid, 0);
                if (c == 1) chk("lat_second_edge", m_valid, 1);
            end
            chk("single_full_never", saw_full, 0);
            cmp_stream("single");
        end

        // fill, overflow and wrap on channel 0
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            wr_en = 16'h0001; wr_data[0 +: DW] = 16'(16'h0100 + k);
            tick();
            if (k == 14) chk("afull_below", afull[0], 0);
            if (k == 15) chk("afull_at", afull[0], 1);
        end
        wr_en = '0;
        chk("fill_reg_valid", m_valid, 1);
        chk("fill_reg_word", m_data, 16'h0101);
        chk("fill_count", cnt_of(0), 16);
        chk("fill_full", full[0], 1);
        chk("fill_no_ovf", overflow[0], 0);
        wr_en = 16'h0001; wr_data[0 +: DW] = 16'h0112;
        tick();
        wr_en = '0;
        chk("ovf_set", overflow[0], 1);
        chk("ovf_count", cnt_of(0), 16);
        exp_q.delete();
        for (int k = 1; k <= 17; k++) exp_q.push_back({4'd0, 16'(16'h0100 + k)});
        m_ready = 1'b1;
        for (int c = 0; c < 25; c++) tick();
        cmp_stream("drain17");
        got_q.delete(); exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            wr_en = 16'h0001; wr_data[0 +: DW] = 16'(16'h0200 + k);
            exp_q.push_back({4'd0, 16'(16'h0200 + k)});
            tick();
        end
        wr_en = '0;
        for (int c = 0; c < 5; c++) tick();
        cmp_stream("wrap40");
        chk("ovf_sticky", overflow[0], 1);

        // round-robin fairness and fixed priority with backpressure
        for (int pm = 0; pm < 2; pm++) begin
            logic        pv;
            logic [19:0] pw;
            do_reset();
            prio_mode = pm[0];
            for (int j = 0; j < 4; j++) begin
                wr_en = '0;
                wr_en[0] = 1'b1;  wr_data[0*DW +: DW]  = 16'(16'h0001 + j);
                wr_en[5] = 1'b1;  wr_data[5*DW +: DW]  = 16'(16'h0501 + j);
                wr_en[15] = 1'b1; wr_data[15*DW +: DW] = 16'(16'h0F01 + j);
                tick();
            end
            wr_en = '0;
            exp_q.delete();
            if (pm == 0) begin
                for (int r = 0; r < 4; r++) begin
                    exp_q.push_back({4'd0,  16'(16'h0001 + r)});
                    exp_q.push_back({4'd5,  16'(16'h0501 + r)});
                    exp_q.push_back({4'd15, 16'(16'h0F01 + r)});
                end
                m_ready = 1'b1;
                for (int c = 0; c < 20; c++) tick();
                cmp_stream("rr");
            end else begin
                for (int r = 0; r < 4; r++) exp_q.push_back({4'd0,  16'(16'h0001 + r)});
                for (int r = 0; r < 4; r++) exp_q.push_back({4'd5,  16'(16'h0501 + r)});
                for (int r = 0; r < 4; r++) exp_q.push_back({4'd15, 16'(16'h0F01 + r)});
                for (int c = 0; c < 40; c++) begin
                    m_ready = (c % 2 == 0);
                    pv = m_valid; pw = {m_ch, m_data};
                    tick();
                    if (!m_ready && pv) begin
                        chk("bp_valid_hold", m_valid, 1);
                        chk("bp_word_hold", {12'h0, m_ch, m_data}, {12'h0, pw});
                    end
                end
                cmp_stream("prio");
            end
        end

        // full channel with simultaneous pop, then reset while streaming
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            wr_en = 16'h0004; wr_data[2*DW +: DW] = 16'(16'h2000 + k);
            tick();
        end
        chk("fp_pre_full", full[2], 1);
        m_ready = 1'b1; wr_data[2*DW +: DW] = 16'h2018;
        tick();
        chk("fp_count", cnt_of(2), 16);
        chk("fp_no_ovf", overflow[2], 0);
        chk("fp_word", m_data, 16'h2002);
        wr_data[2*DW +: DW] = 16'h2019;
        tick();
        chk("fp_stream_count", cnt_of(2), 16);
        chk("fp_stream_word", m_data, 16'h2003);
        rst = 1'b1; wr_en = 16'h0005;
        tick();
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 16'hFFFF);
        chk("mid_rst_ovf", overflow, 0);
        rst = 1'b0; wr_en = '0;
        tick();
        chk("post_rst_valid", m_valid, 0);
        chk("post_rst_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
